arm_multicycle_controller: RTL

ARM_MULTICYCLE_CONTROLLER -- requirements
Module: arm_multicycle_controller

---
 rtl/arm_mc_pkg.sv | 72 +++++++
 rtl/arm_mc_cond_logic.sv | 54 +++++
 rtl/arm_multicycle_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_pkg.sv
// arm_mc_pkg: shared state encodings, condition/ALU enums, mux selects and the
// data-processing decode helper for the ARM multicycle controller.
package arm_mc_pkg;

    // FSM state encodings, also exported on o_State for debug
    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StMemAdr = 4'd2;
    localparam logic [3:0] StMemRd  = 4'd3;
    localparam logic [3:0] StMemWb  = 4'd4;
    localparam logic [3:0] StMemWr  = 4'd5;
    localparam logic [3:0] StExecR  = 4'd6;
    localparam logic [3:0] StExecI  = 4'd7;
    localparam logic [3:0] StAluWb  = 4'd8;
    localparam logic [3:0] StBranch = 4'd9;

    typedef enum logic [3:0] {
        CondEq = 4'b0000, CondNe = 4'b0001, CondCs = 4'b0010, CondCc = 4'b0011,
        CondMi = 4'b0100, CondPl = 4'b0101, CondVs = 4'b0110, CondVc = 4'b0111,
        CondHi = 4'b1000, CondLs = 4'b1001, CondGe = 4'b1010, CondLt = 4'b1011,
        CondGt = 4'b1100, CondLe = 4'b1101, CondAl = 4'b1110, CondNv = 4'b1111
    } cond_e;

    typedef enum logic [2:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOrr = 3'd3,
        AluEor = 3'd4
    } alu_op_e;

    // Mux select constants
    localparam logic       AdrPc      = 1'b0;
    localparam logic       AdrAluOut  = 1'b1;
    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResData    = 2'b01;
    localparam logic [1:0] ResAlu     = 2'b10;
    localparam logic [1:0] SrcARd1    = 2'b00;
    localparam logic [1:0] SrcAPc     = 2'b01;
    localparam logic [1:0] SrcAAluOut = 2'b10;
    localparam logic [1:0] SrcBRd2    = 2'b00;
    localparam logic [1:0] SrcBImm    = 2'b01;
    localparam logic [1:0] SrcBFour   = 2'b10;
    localparam logic [1:0] Imm8       = 2'b00;
    localparam logic [1:0] Imm12      = 2'b01;
    localparam logic [1:0] Imm24      = 2'b10;

    typedef struct packed {
        alu_op_e alu_op;
        logic    reg_write;
        logic    flag_nz;
        logic    flag_cv;
    } dp_ctrl_t;

    // funct[4:1] -> ALU op, register write and which flag groups may update
    function automatic dp_ctrl_t dp_decode(input logic [3:0] cmd);
        dp_ctrl_t c;
        c = '{AluAdd, 1'b0, 1'b0, 1'b0};
        case (cmd)
            4'b0100: c = '{AluAdd, 1'b1, 1'b1, 1'b1};
            4'b0010: c = '{AluSub, 1'b1, 1'b1, 1'b1};
            4'b0000: c = '{AluAnd, 1'b1, 1'b1, 1'b0};
            4'b1100: c = '{AluOrr, 1'b1, 1'b1, 1'b0};
            4'b0001: c = '{AluEor, 1'b1, 1'b1, 1'b0};
            4'b1010: c = '{AluSub, 1'b0, 1'b1, 1'b1};
            4'b1000: c = '{AluAnd, 1'b0, 1'b1, 1'b0};
            default: c = '{AluAdd, 1'b0, 1'b0, 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/arm_mc_cond_logic.sv
// arm_mc_cond_logic: NZCV flag register plus ARM condition-code evaluation.
module arm_mc_cond_logic
    import arm_mc_pkg::*;
(
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [3:0] i_Cond,
    input  logic [3:0] i_ALU_Flags,
    input  logic [1:0] i_Flag_Write,  // bit1 = NZ group, bit0 = CV group
    output logic       o_Cond_Ex
);

    logic [3:0] flags_q, flags_d;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    // Evaluate the instruction condition against the stored flags
    always_comb begin
        o_Cond_Ex = 1'b0;
        case (cond_e'(i_Cond))
            CondEq:  o_Cond_Ex = z;
            CondNe:  o_Cond_Ex = ~z;
            CondCs:  o_Cond_Ex = c;
            CondCc:  o_Cond_Ex = ~c;
            CondMi:  o_Cond_Ex = n;
            CondPl:  o_Cond_Ex = ~n;
            CondVs:  o_Cond_Ex = v;
            CondVc:  o_Cond_Ex = ~v;
            CondHi:  o_Cond_Ex = c & ~z;
            CondLs:  o_Cond_Ex = ~c | z;
            CondGe:  o_Cond_Ex = (n == v);
            CondLt:  o_Cond_Ex = (n != v);
            CondGt:  o_Cond_Ex = ~z & (n == v);
            CondLe:  o_Cond_Ex = z | (n != v);
            CondAl:  o_Cond_Ex = 1'b1;
            default: o_Cond_Ex = 1'b0;  // 1111 never executes
        endcase
    end

    // Flags update only when the instruction itself passes its condition
    always_comb begin
        flags_d = flags_q;
        if (o_Cond_Ex && i_Flag_Write[1]) flags_d[3:2] = i_ALU_Flags[3:2];
        if (o_Cond_Ex && i_Flag_Write[0]) flags_d[1:0] = i_ALU_Flags[1:0];
    end

    // Flag register, cleared by reset
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) flags_q <= 4'b0000;
        else         flags_q <= flags_d;
    end

endmodule

// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller: Moore FSM control unit for a multicycle ARM datapath.
// Optional build macro ARM_MC_MEM_WAIT_EN adds i_Mem_Ready and stalls FETCH, MEMRD
// and MEMWR until memory is ready; otherwise memory is treated as always ready.
module arm_multicycle_controller
    import arm_mc_pkg::*;
#(
    parameter int unsigned INSTR_W    = 32,
    parameter int unsigned ALU_CTRL_W = 3   // must be at least 3
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic [INSTR_W-1:0]    i_Instr,
    input  logic [3:0]            i_ALU_Flags,
    output logic                  o_PC_Write,
    output logic                  o_Adr_Src,
    output logic                  o_IR_Write,
    output logic                  o_Mem_Write,
    output logic                  o_Reg_Write,
    output logic [1:0]            o_Result_Src,
    output logic [1:0]            o_ALU_SrcA,
    output logic [1:0]            o_ALU_SrcB,
    output logic [1:0]            o_Imm_Src,
    output logic [1:0]            o_Reg_Src,
    output logic [ALU_CTRL_W-1:0] o_ALU_Control,
    output logic [3:0]            o_State
`ifdef ARM_MC_MEM_WAIT_EN
    ,
    input  logic                  i_Mem_Ready
`endif
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_ready;
    logic       cond_ex;
    logic [1:0] flag_write;
    logic [3:0] state_q, state_d;
    alu_op_e    alu_op;
    dp_ctrl_t   dp;
    logic       is_store;
    logic       rd_is_pc;

    if (INSTR_W == 32) begin : g_full
        assign cond  = i_Instr[31:28];
        assign op    = i_Instr[27:26];
        assign funct = i_Instr[25:20];
        assign rd    = i_Instr[15:12];
        logic unused_instr_bits;
        assign unused_instr_bits = ^{i_Instr[19:16], i_Instr[11:0]};
    end else begin : g_compact
        assign cond  = i_Instr[15:12];
        assign op    = i_Instr[11:10];
        assign funct = i_Instr[9:4];
        assign rd    = i_Instr[3:0];
    end

`ifdef ARM_MC_MEM_WAIT_EN
    assign mem_ready = i_Mem_Ready;
`else
    assign mem_ready = 1'b1;
`endif

    assign dp       = dp_decode(funct[4:1]);
    assign is_store = (op == 2'b01) && !funct[0];
    assign rd_is_pc = (rd == 4'd15);

    // Flags are captured on the edge that ends EXECR/EXECI when S is set
    assign flag_write = ((state_q == StExecR || state_q == StExecI) && funct[0])
                        ? {dp.flag_nz, dp.flag_cv} : 2'b00;

    arm_mc_cond_logic u_cond (
        .i_CLK        (i_CLK),
        .i_RESET      (i_RESET),
        .i_Cond       (cond),
        .i_ALU_Flags  (i_ALU_Flags),
        .i_Flag_Write (flag_write),
        .o_Cond_Ex    (cond_ex)
    );

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;  // undefined, no side effects
                endcase
            end
            StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr:  if (mem_ready) state_d = StFetch;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            default:  state_d = StFetch;
        endcase
    end

    // State register
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) state_q <= StFetch;
        else         state_q <= state_d;
    end

    // Moore outputs per state; everything forced low while reset is held
    always_comb begin
        o_PC_Write   = 1'b0;
        o_Adr_Src    = AdrPc;
        o_IR_Write   = 1'b0;
        o_Mem_Write  = 1'b0;
        o_Reg_Write  = 1'b0;
        o_Result_Src = ResAluOut;
        o_ALU_SrcA   = SrcARd1;
        o_ALU_SrcB   = SrcBRd2;
        o_Imm_Src    = Imm8;
        o_Reg_Src    = 2'b00;
        alu_op       = AluAdd;
        case (state_q)
            StFetch: begin
                o_IR_Write   = mem_ready;
                o_PC_Write   = mem_ready;
                o_ALU_SrcA   = SrcAPc;
                o_ALU_SrcB   = SrcBFour;
                o_Result_Src = ResAlu;
            end
            StDecode: begin
                // PC+8 precompute; R15 read as Rn, store data read via Rd
                o_ALU_SrcA   = SrcAPc;
                o_ALU_SrcB   = SrcBFour;
                o_Result_Src = ResAlu;
                o_Reg_Src    = {is_store, 1'b1};
            end
            StMemAdr: begin
                o_ALU_SrcB = SrcBImm;
                o_Imm_Src  = Imm12;
                o_Reg_Src  = {is_store, 1'b0};
            end
            StMemRd: o_Adr_Src = AdrAluOut;
            StMemWb: begin
                o_Result_Src = ResData;
                o_Reg_Write  = cond_ex;
                o_PC_Write   = cond_ex & rd_is_pc;
            end
            StMemWr: begin
                o_Adr_Src   = AdrAluOut;
                o_Mem_Write = cond_ex & mem_ready;
                o_Reg_Src   = 2'b10;
            end
            StExecR: alu_op = dp.alu_op;
            StExecI: begin
                alu_op     = dp.alu_op;
                o_ALU_SrcB = SrcBImm;
            end
            StAluWb: begin
                o_Result_Src = ResAluOut;
                o_Reg_Write  = cond_ex & dp.reg_write;
                o_PC_Write   = cond_ex & dp.reg_write & rd_is_pc;
            end
            StBranch: begin
                o_ALU_SrcA   = SrcAAluOut;
                o_ALU_SrcB   = SrcBImm;
                o_Imm_Src    = Imm24;
                o_Result_Src = ResAlu;
                o_PC_Write   = cond_ex;
            end
            default: ;
        endcase
        o_ALU_Control = ALU_CTRL_W'(alu_op);
        o_State       = state_q;
        if (i_RESET) begin
            o_PC_Write    = 1'b0;
            o_Adr_Src     = 1'b0;
            o_IR_Write    = 1'b0;
            o_Mem_Write   = 1'b0;
            o_Reg_Write   = 1'b0;
            o_Result_Src  = 2'b00;
            o_ALU_SrcA    = 2'b00;
            o_ALU_SrcB    = 2'b00;
            o_Imm_Src     = 2'b00;
            o_Reg_Src     = 2'b00;
            o_ALU_Control = '0;
            o_State       = 4'd0;
        end
    end

endmodule
